// File: rtl/cursor_sched_pkg.sv
// Shared types and defaults for the cursor position scheduler.
// Optional build macro CURSOR_SCHED_CLAMP_EN is consumed by cursor_pos_scheduler.
package cursor_sched_pkg;

  localparam int unsigned DEF_POS_W    = 12;
  localparam int unsigned DEF_H_ACTIVE = 800;
  localparam int unsigned DEF_V_ACTIVE = 600;
  localparam int unsigned DEF_X_RESET  = 400;
  localparam int unsigned DEF_Y_RESET  = 300;
  localparam int unsigned GRANT_W      = 3;

  typedef enum logic [2:0] {
    ACTIVE,
    ARB,
    CLAMP,
    COMMIT,
    HOLD
  } sched_state_t;

endpackage

// File: rtl/cursor_pos_scheduler_rr_arbiter.sv
// Combinational round-robin select: searches ptr+1, ptr+2, ... modulo NUM_REQ
// and returns the first asserted request as one-hot grant plus its index.
module rr_arbiter
  import cursor_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [GRANT_W-1:0] ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [GRANT_W-1:0] grant_idx,
  output logic               any_valid
);

  // Outer loop walks priority order; inner loop keeps every index constant.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!any_valid && valid[i] &&
            (i == ((int'(ptr) + off) % NUM_REQ))) begin
          any_valid    = 1'b1;
          grant[i]     = 1'b1;
          grant_idx    = GRANT_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/cursor_pos_scheduler.sv
// Frame-synchronous round-robin scheduler for cursor overlay coordinates.
// Define CURSOR_SCHED_CLAMP_EN to saturate coordinates to the visible area.
module cursor_pos_scheduler
  import cursor_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned POS_W    = DEF_POS_W,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned X_RESET  = DEF_X_RESET,
  parameter int unsigned Y_RESET  = DEF_Y_RESET
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic                     vblnk_in,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*POS_W-1:0] req_x,
  input  logic [NUM_REQ*POS_W-1:0] req_y,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [POS_W-1:0]         xpos_out,
  output logic [POS_W-1:0]         ypos_out,
  output logic                     pos_update,
  output logic [GRANT_W-1:0]       grant_id
);

`ifdef CURSOR_SCHED_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  localparam logic [POS_W-1:0] X_MAX = POS_W'(H_ACTIVE - 1);
  localparam logic [POS_W-1:0] Y_MAX = POS_W'(V_ACTIVE - 1);

  sched_state_t       state, state_next;
  logic               vblnk_d;
  logic               rise;
  logic [GRANT_W-1:0] rr_ptr;
  logic [GRANT_W-1:0] win_id;
  logic [POS_W-1:0]   cap_x, cap_y, res_x, res_y;
  logic [POS_W-1:0]   sel_x, sel_y, clamp_x, clamp_y;
  logic [NUM_REQ-1:0] grant;
  logic [GRANT_W-1:0] gnt_idx;
  logic               any_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (gnt_idx),
    .any_valid (any_valid)
  );

  assign rise = vblnk_in & ~vblnk_d;

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == GRANT_W'(i)) begin
        sel_x = req_x[i*POS_W +: POS_W];
        sel_y = req_y[i*POS_W +: POS_W];
      end
    end
  end

  assign clamp_x = (CLAMP_EN && (cap_x > X_MAX)) ? X_MAX : cap_x;
  assign clamp_y = (CLAMP_EN && (cap_y > Y_MAX)) ? Y_MAX : cap_y;

  always_ff @(posedge pclk) begin
    if (rst) state <= ACTIVE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    unique case (state)
      ACTIVE: if (rise) state_next = ARB;
      ARB: begin
        req_ready  = grant;
        state_next = any_valid ? CLAMP : HOLD;
      end
      CLAMP:  state_next = COMMIT;
      COMMIT: state_next = HOLD;
      HOLD:   if (!vblnk_in) state_next = ACTIVE;
      default: state_next = ACTIVE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      vblnk_d    <= 1'b0;
      rr_ptr     <= GRANT_W'(NUM_REQ - 1);
      win_id     <= '0;
      cap_x      <= '0;
      cap_y      <= '0;
      res_x      <= '0;
      res_y      <= '0;
      xpos_out   <= POS_W'(X_RESET);
      ypos_out   <= POS_W'(Y_RESET);
      pos_update <= 1'b0;
      grant_id   <= '0;
    end else begin
      vblnk_d    <= vblnk_in;
      pos_update <= 1'b0;
      case (state)
        ARB: begin
          if (any_valid) begin
            cap_x  <= sel_x;
            cap_y  <= sel_y;
            win_id <= gnt_idx;
          end
        end
        CLAMP: begin
          res_x <= clamp_x;
          res_y <= clamp_y;
        end
        COMMIT: begin
          xpos_out   <= res_x;
          ypos_out   <= res_y;
          grant_id   <= win_id;
          rr_ptr     <= win_id;
          pos_update <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cursor_pos_scheduler.sv
// Directed self-checking bench for cursor_pos_scheduler (NUM_REQ=2, 12-bit coords).
module tb_cursor_pos_scheduler;

  localparam int unsigned NREQ = 2;
  localparam int unsigned PW   = 12;

  logic            pclk = 1'b0;
  logic            rst = 1'b1;
  logic            vblnk_in = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*PW-1:0] req_x = '0;
  logic [NREQ*PW-1:0] req_y = '0;
  logic [NREQ-1:0] req_ready;
  logic [PW-1:0]   xpos_out, ypos_out;
  logic            pos_update;
  logic [2:0]      grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  cursor_pos_scheduler #(
    .NUM_REQ (NREQ),
    .POS_W   (PW),
    .H_ACTIVE(800),
    .V_ACTIVE(600),
    .X_RESET (400),
    .Y_RESET (300)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .vblnk_in  (vblnk_in),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ready (req_ready),
    .xpos_out  (xpos_out),
    .ypos_out  (ypos_out),
    .pos_update(pos_update),
    .grant_id  (grant_id)
  );

  always #5 pclk = ~pclk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; vblnk_in = 1'b0; req_valid = '0;
    cyc(3);
    n_checks++; if (xpos_out !== 12'd400) begin n_fail++; $display("FAIL reset_x: got %0d expected 400", xpos_out); end
    n_checks++; if (ypos_out !== 12'd300) begin n_fail++; $display("FAIL reset_y: got %0d expected 300", ypos_out); end
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
    n_checks++; if (pos_update !== 1'b0) begin n_fail++; $display("FAIL reset_upd: got %b expected 0", pos_update); end
    n_checks++; if (grant_id !== 3'd0) begin n_fail++; $display("FAIL reset_gid: got %0d expected 0", grant_id); end
    rst = 1'b0;
    cyc(2);
  endtask

  task automatic test_single;
    req_valid = 2'b01; req_x = {12'd0, 12'd123}; req_y = {12'd0, 12'd45};
    cyc(2);
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL single_wait_ready: got %b expected 00", req_ready); end
    vblnk_in = 1'b1;
    cyc(1);  // edge k
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b expected 01", req_ready); end
    cyc(1);
    req_valid = '0;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL single_ready_drop: got %b expected 00", req_ready); end
    cyc(1);
    n_checks++; if (pos_update !== 1'b0 || xpos_out !== 12'd400) begin n_fail++; $display("FAIL single_early: got upd=%b x=%0d expected upd=0 x=400", pos_update, xpos_out); end
    cyc(1);  // edge k+3
    n_checks++; if (xpos_out !== 12'd123 || ypos_out !== 12'd45) begin n_fail++; $display("FAIL single_pos: got %0d/%0d expected 123/45", xpos_out, ypos_out); end
    n_checks++; if (pos_update !== 1'b1) begin n_fail++; $display("FAIL single_upd: got %b expected 1", pos_update); end
    n_checks++; if (grant_id !== 3'd0) begin n_fail++; $display("FAIL single_gid: got %0d expected 0", grant_id); end
    cyc(1);
    n_checks++; if (pos_update !== 1'b0) begin n_fail++; $display("FAIL single_upd_pulse: got %b expected 0", pos_update); end
    vblnk_in = 1'b0;
    cyc(3);
  endtask

  task automatic test_fairness;
    logic [2:0]  exp_gid [4] = '{3'd0, 3'd1, 3'd0, 3'd1};
    logic [11:0] exp_x   [4] = '{12'd10, 12'd30, 12'd10, 12'd30};
    logic [1:0]  exp_rdy;
    int pulses;
    rst = 1'b1; cyc(2); rst = 1'b0; cyc(1);
    req_valid = 2'b11; req_x = {12'd30, 12'd10}; req_y = {12'd40, 12'd20};
    for (int f = 0; f < 4; f++) begin
      exp_rdy = (exp_gid[f] == 3'd0) ? 2'b01 : 2'b10;
      pulses = 0;
      vblnk_in = 1'b1;
      cyc(1);
      n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL fair_ready[%0d]: got %b expected %b", f, req_ready, exp_rdy); end
      for (int c = 0; c < 6; c++) begin
        cyc(1);
        if (pos_update === 1'b1) pulses++;
      end
      n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL fair_pulses[%0d]: got %0d expected 1", f, pulses); end
      n_checks++; if (grant_id !== exp_gid[f]) begin n_fail++; $display("FAIL fair_gid[%0d]: got %0d expected %0d", f, grant_id, exp_gid[f]); end
      n_checks++; if (xpos_out !== exp_x[f]) begin n_fail++; $display("FAIL fair_x[%0d]: got %0d expected %0d", f, xpos_out, exp_x[f]); end
      vblnk_in = 1'b0;
      cyc(3);
    end
    req_valid = '0;
  endtask

  task automatic test_clamp;
`ifdef CURSOR_SCHED_CLAMP_EN
    logic [11:0] ex = 12'd799, ey = 12'd599;
`else
    logic [11:0] ex = 12'd1023, ey = 12'd700;
`endif
    req_valid = 2'b10; req_x = {12'd1023, 12'd0}; req_y = {12'd700, 12'd0};
    vblnk_in = 1'b1;
    cyc(1);
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL clamp_ready: got %b expected 10", req_ready); end
    cyc(1);
    req_valid = '0;
    cyc(2);
    n_checks++; if (xpos_out !== ex || ypos_out !== ey) begin n_fail++; $display("FAIL clamp_pos: got %0d/%0d expected %0d/%0d", xpos_out, ypos_out, ex, ey); end
    n_checks++; if (grant_id !== 3'd1 || pos_update !== 1'b1) begin n_fail++; $display("FAIL clamp_gid: got gid=%0d upd=%b expected gid=1 upd=1", grant_id, pos_update); end
    vblnk_in = 1'b0;
    cyc(3);
  endtask

  task automatic test_empty_and_late;
    logic [11:0] hx, hy;
    int pulses;
    hx = xpos_out; hy = ypos_out;
    pulses = 0;
    vblnk_in = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cyc(1);
      if (pos_update === 1'b1) pulses++;
    end
    vblnk_in = 1'b0;
    cyc(3);
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL empty_pulses: got %0d expected 0", pulses); end
    n_checks++; if (xpos_out !== hx || ypos_out !== hy) begin n_fail++; $display("FAIL empty_hold: got %0d/%0d expected %0d/%0d", xpos_out, ypos_out, hx, hy); end
    // Request appears only after the ARB cycle has passed.
    vblnk_in = 1'b1;
    cyc(2);
    req_valid = 2'b01; req_x = {12'd0, 12'd55}; req_y = {12'd0, 12'd66};
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      if (req_ready !== 2'b00) pulses++;
      cyc(1);
      if (pos_update === 1'b1) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL late_no_xfer: got %0d events expected 0", pulses); end
    vblnk_in = 1'b0;
    cyc(3);
    vblnk_in = 1'b1;
    cyc(1);
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL late_ready: got %b expected 01", req_ready); end
    cyc(1);
    req_valid = '0;
    cyc(2);
    n_checks++; if (xpos_out !== 12'd55 || ypos_out !== 12'd66 || grant_id !== 3'd0) begin n_fail++; $display("FAIL late_pos: got %0d/%0d gid=%0d expected 55/66 gid=0", xpos_out, ypos_out, grant_id); end
    vblnk_in = 1'b0;
    cyc(3);
  endtask

  task automatic test_mid_reset;
    int pulses;
    req_valid = 2'b10; req_x = {12'd200, 12'd0}; req_y = {12'd100, 12'd0};
    vblnk_in = 1'b1;
    cyc(1);
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL mrst_ready: got %b expected 10", req_ready); end
    cyc(1);  // now in CLAMP
    rst = 1'b1; vblnk_in = 1'b0; req_valid = '0;
    cyc(1);
    rst = 1'b0;
    n_checks++; if (req_ready !== 2'b00 || pos_update !== 1'b0) begin n_fail++; $display("FAIL mrst_ctl: got rdy=%b upd=%b expected 00/0", req_ready, pos_update); end
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      cyc(1);
      if (pos_update === 1'b1) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL mrst_no_commit: got %0d pulses expected 0", pulses); end
    n_checks++; if (xpos_out !== 12'd400 || ypos_out !== 12'd300 || grant_id !== 3'd0) begin n_fail++; $display("FAIL mrst_pos: got %0d/%0d gid=%0d expected 400/300 gid=0", xpos_out, ypos_out, grant_id); end
    // vblank already high while leaving reset counts as a rise.
    rst = 1'b1; vblnk_in = 1'b1;
    req_valid = 2'b01; req_x = {12'd0, 12'd7}; req_y = {12'd0, 12'd8};
    cyc(2);
    rst = 1'b0;
    cyc(1);
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rstvb_ready: got %b expected 01", req_ready); end
    cyc(1);
    req_valid = '0;
    cyc(2);
    n_checks++; if (xpos_out !== 12'd7 || ypos_out !== 12'd8 || pos_update !== 1'b1) begin n_fail++; $display("FAIL rstvb_pos: got %0d/%0d upd=%b expected 7/8 upd=1", xpos_out, ypos_out, pos_update); end
    vblnk_in = 1'b0;
    cyc(3);
  endtask

  task automatic test_short_vblank;
    req_valid = 2'b10; req_x = {12'd300, 12'd0}; req_y = {12'd200, 12'd0};
    vblnk_in = 1'b1;
    cyc(1);
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL short_ready: got %b expected 10", req_ready); end
    cyc(1);
    vblnk_in = 1'b0; req_valid = '0;
    cyc(2);
    n_checks++; if (xpos_out !== 12'd300 || ypos_out !== 12'd200 || pos_update !== 1'b1 || grant_id !== 3'd1) begin n_fail++; $display("FAIL short_commit: got %0d/%0d upd=%b gid=%0d expected 300/200 upd=1 gid=1", xpos_out, ypos_out, pos_update, grant_id); end
    cyc(2);
    req_valid = 2'b01; req_x = {12'd0, 12'd11}; req_y = {12'd0, 12'd22};
    vblnk_in = 1'b1;
    cyc(1);
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL short_next_ready: got %b expected 01", req_ready); end
    cyc(1);
    req_valid = '0;
    cyc(2);
    n_checks++; if (xpos_out !== 12'd11 || ypos_out !== 12'd22 || grant_id !== 3'd0) begin n_fail++; $display("FAIL short_next_pos: got %0d/%0d gid=%0d expected 11/22 gid=0", xpos_out, ypos_out, grant_id); end
    vblnk_in = 1'b0;
    cyc(3);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_clamp();
    test_empty_and_late();
    test_mid_reset();
    test_short_vblank();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
